// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch and dcache-miss stalls.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
    parameter int unsigned MISS_TIMEOUT = 1023,
    parameter int unsigned CNT_W        = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_use_i,
    input  logic        branch_taken_i,
    input  logic        mem_stall_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_en_o,
    output logic        timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] bubble_cycles_o,
    output logic [31:0] flush_count_o
);

    typedef enum logic [0:0] {StRun, StMiss} state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MISS_TIMEOUT);

    state_e           state_q;
    logic             pend_flush_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic             timeout_q;

    // Mealy outputs so a stall takes effect in the cycle it is raised.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_en_o     = 1'b0;
        if (rst_i) begin
            case (state_q)
                StRun: begin
                    if (mem_stall_i) begin
                        pc_write_o = 1'b0;
                    end else if (ld_use_i) begin
                        idex_bubble_o = 1'b1;
                        pipe_en_o     = 1'b1;
                        ifid_flush_o  = pend_flush_q;
                        ifid_write_o  = pend_flush_q;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                        pipe_en_o    = 1'b1;
                        ifid_flush_o = branch_taken_i | pend_flush_q;
                    end
                end
                default: begin
                    pc_write_o = 1'b0;
                end
            endcase
        end
    end

    assign timeout_o = timeout_q & rst_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StRun;
            pend_flush_q <= 1'b0;
            miss_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (mem_stall_i) begin
                        state_q      <= StMiss;
                        miss_cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        pend_flush_q <= branch_taken_i;
                    end else begin
                        pend_flush_q <= 1'b0;
                    end
                end
                default: begin
                    // Branches resolved during the freeze are replayed on the first RUN cycle.
                    pend_flush_q <= pend_flush_q | branch_taken_i;
                    if (mem_stall_i) begin
                        if (miss_cnt_q == TimeoutCnt) begin
                            timeout_q <= 1'b1;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_q    <= StRun;
                        miss_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (!pipe_en_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (idex_bubble_o) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (ifid_flush_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o  = rst_i ? stall_cnt_q  : 32'd0;
    assign bubble_cycles_o = rst_i ? bubble_cnt_q : 32'd0;
    assign flush_count_o   = rst_i ? flush_cnt_q  : 32'd0;
`else
    assign stall_cycles_o  = 32'd0;
    assign bubble_cycles_o = 32'd0;
    assign flush_count_o   = 32'd0;
`endif

endmodule
